// File: rtl/pmem_loader_if.sv
// rtl/pmem_loader_if.sv - CPU memory ports, byte loader stream and run control for pmem_loader
interface pmem_loader_if;
    logic [7:0]  i_addr;
    logic [15:0] i_datain;
    logic [7:0]  d_addr;
    logic [15:0] d_dataout;
    logic        d_we;
    logic [15:0] d_datain;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        run_stop;
    logic        cpu_enable;
    logic        cpu_start;
    logic        busy;
    logic [8:0]  ld_count;
    logic        err;

    modport master (
        output i_addr, d_addr, d_dataout, d_we, ld_valid, ld_data, ld_last, run_stop,
        input  i_datain, d_datain, ld_ready, cpu_enable, cpu_start, busy, ld_count, err
    );

    modport slave (
        input  i_addr, d_addr, d_dataout, d_we, ld_valid, ld_data, ld_last, run_stop,
        output i_datain, d_datain, ld_ready, cpu_enable, cpu_start, busy, ld_count, err
    );
endinterface

// File: rtl/pmem_loader.sv
// rtl/pmem_loader.sv - byte-stream program loader with instruction/data memories and CPU start/run control
module pmem_loader (
    input  logic          clock,
    input  logic          reset,
    pmem_loader_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, START, RUN} state_t;

    state_t      state;
    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    logic        hi_phase;
    logic [7:0]  hi_byte;
    logic [8:0]  ld_count;
    logic        err;
    logic        ld_ready;
    logic        cpu_enable;
    logic        cpu_start;
    logic        busy;

    logic        accept;
    logic        imem_we;
    logic [15:0] imem_wdata;
    logic        dmem_we;

    assign accept  = bus.ld_valid && ld_ready;
    assign dmem_we = !reset && (state == RUN) && bus.d_we;

    // A word is committed either on its low byte, or early when ld_last
    // arrives on a high byte (padded with zeros).
    always_comb begin
        imem_we    = 1'b0;
        imem_wdata = 16'h0000;
        if (!reset && accept) begin
            if (!hi_phase) begin
                imem_we    = 1'b1;
                imem_wdata = {hi_byte, bus.ld_data};
            end else if (bus.ld_last) begin
                imem_we    = 1'b1;
                imem_wdata = {bus.ld_data, 8'h00};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (imem_we) imem[ld_count[7:0]] <= imem_wdata;
        if (dmem_we) dmem[bus.d_addr] <= bus.d_dataout;
    end

    assign bus.i_datain   = imem[bus.i_addr];
    assign bus.d_datain   = dmem[bus.d_addr];
    assign bus.ld_ready   = ld_ready;
    assign bus.cpu_enable = cpu_enable;
    assign bus.cpu_start  = cpu_start;
    assign bus.busy       = busy;
    assign bus.ld_count   = ld_count;
    assign bus.err        = err;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            ld_count   <= 9'd0;
            err        <= 1'b0;
            hi_phase   <= 1'b1;
            hi_byte    <= 8'h00;
            ld_ready   <= 1'b1;
            cpu_enable <= 1'b0;
            cpu_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (accept) begin
                        if (imem_we) begin
                            ld_count <= ld_count + 9'd1;
                            hi_phase <= 1'b1;
                            // Stop on ld_last or once the final address has been filled.
                            if (bus.ld_last || ld_count == 9'd255) begin
                                state      <= START;
                                err        <= err | hi_phase | !bus.ld_last;
                                ld_ready   <= 1'b0;
                                cpu_enable <= 1'b1;
                                cpu_start  <= 1'b1;
                                busy       <= 1'b1;
                            end else begin
                                state <= LOAD;
                                busy  <= 1'b1;
                            end
                        end else begin
                            hi_byte  <= bus.ld_data;
                            hi_phase <= 1'b0;
                            state    <= LOAD;
                            busy     <= 1'b1;
                        end
                    end
                end
                START: begin
                    state     <= RUN;
                    cpu_start <= 1'b0;
                    busy      <= 1'b0;
                end
                RUN: begin
                    if (bus.run_stop) begin
                        state      <= IDLE;
                        ld_count   <= 9'd0;
                        err        <= 1'b0;
                        ld_ready   <= 1'b1;
                        cpu_enable <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pmem_loader.sv
// tb/tb_pmem_loader.sv - directed bench with per-cycle model comparison for pmem_loader
module tb_pmem_loader;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    pmem_loader_if bus ();

    pmem_loader dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: loader modes, word count and memory images.
    localparam int M_IDLE = 0, M_LOAD = 1, M_START = 2, M_RUN = 3;
    int          mode;
    int          words;
    bit          merr;
    bit          have_hi;
    logic [7:0]  hi;
    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    bit          ik [256];
    bit          dk [256];
    bit          mvalid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mvalid  = 1'b1;
            mode    = M_IDLE;
            words   = 0;
            merr    = 1'b0;
            have_hi = 1'b0;
        end else if (mvalid) begin
            case (mode)
                M_IDLE, M_LOAD: begin
                    if (bus.ld_valid) begin
                        if (have_hi || bus.ld_last) begin
                            m_imem[words] = have_hi ? {hi, bus.ld_data} : {bus.ld_data, 8'h00};
                            ik[words] = 1'b1;
                            if (!have_hi) merr = 1'b1;
                            words++;
                            have_hi = 1'b0;
                            if (bus.ld_last) mode = M_START;
                            else if (words == 256) begin
                                mode = M_START;
                                merr = 1'b1;
                            end else mode = M_LOAD;
                        end else begin
                            hi      = bus.ld_data;
                            have_hi = 1'b1;
                            mode    = M_LOAD;
                        end
                    end
                end
                M_START: mode = M_RUN;
                default: begin
                    if (bus.d_we) begin
                        m_dmem[bus.d_addr] = bus.d_dataout;
                        dk[bus.d_addr] = 1'b1;
                    end
                    if (bus.run_stop) begin
                        mode  = M_IDLE;
                        words = 0;
                        merr  = 1'b0;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (bus.cpu_start === 1'b1) pulses++;
        if (mvalid) begin
            check("ld_ready",   32'(bus.ld_ready),   32'(mode == M_IDLE || mode == M_LOAD));
            check("busy",       32'(bus.busy),       32'(mode == M_LOAD || mode == M_START));
            check("cpu_enable", 32'(bus.cpu_enable), 32'(mode == M_START || mode == M_RUN));
            check("cpu_start",  32'(bus.cpu_start),  32'(mode == M_START));
            check("ld_count",   32'(bus.ld_count),   32'(words));
            check("err",        32'(bus.err),        32'(merr));
            if (ik[bus.i_addr]) check("i_datain", 32'(bus.i_datain), 32'(m_imem[bus.i_addr]));
            if (dk[bus.d_addr]) check("d_datain", 32'(bus.d_datain), 32'(m_dmem[bus.d_addr]));
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        bus.ld_valid = 1'b1;
        bus.ld_data  = b;
        bus.ld_last  = last;
        step();
        bus.ld_valid = 1'b0;
        bus.ld_last  = 1'b0;
    endtask

    task automatic stop_run();
        bus.run_stop = 1'b1;
        step();
        bus.run_stop = 1'b0;
    endtask

    task automatic peek_imem(input string name, input logic [7:0] a, input logic [15:0] exp);
        bus.i_addr = a;
        #1;
        check(name, 32'(bus.i_datain), 32'(exp));
    endtask

    int p0;

    initial begin
        reset         = 1'b1;
        bus.i_addr    = 8'h00;
        bus.d_addr    = 8'h00;
        bus.d_dataout = 16'h0000;
        bus.d_we      = 1'b0;
        bus.ld_valid  = 1'b0;
        bus.ld_data   = 8'h00;
        bus.ld_last   = 1'b0;
        bus.run_stop  = 1'b0;
        step();
        step();
        check("rst_ld_ready",   32'(bus.ld_ready),   32'd1);
        check("rst_cpu_enable", 32'(bus.cpu_enable), 32'd0);
        check("rst_cpu_start",  32'(bus.cpu_start),  32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_ld_count",   32'(bus.ld_count),   32'd0);
        check("rst_err",        32'(bus.err),        32'd0);
        reset = 1'b0;

        // Four-byte load
        p0 = pulses;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b1);
        check("load_start_pulse", 32'(bus.cpu_start), 32'd1);
        step();
        check("load_start_drop", 32'(bus.cpu_start), 32'd0);
        step(); step(); step();
        check("load_pulses",   32'(pulses),         32'(p0 + 1));
        check("load_enable",   32'(bus.cpu_enable), 32'd1);
        check("load_count",    32'(bus.ld_count),   32'd2);
        check("load_err",      32'(bus.err),        32'd0);
        peek_imem("load_imem1", 8'h01, 16'h5678);
        peek_imem("load_imem0", 8'h00, 16'h1234);

        // Data memory write in RUN: old value in the write cycle, new one after
        bus.d_we = 1'b1; bus.d_addr = 8'h10; bus.d_dataout = 16'h1111;
        step();
        bus.d_dataout = 16'hBEEF;
        #1;
        check("dmem_same_cycle", 32'(bus.d_datain), 32'h1111);
        step();
        bus.d_we = 1'b0;
        #1;
        check("dmem_next_cycle", 32'(bus.d_datain), 32'hBEEF);

        stop_run();
        check("stop_enable", 32'(bus.cpu_enable), 32'd0);
        check("stop_count",  32'(bus.ld_count),   32'd0);
        check("stop_ready",  32'(bus.ld_ready),   32'd1);

        // Data write outside RUN is ignored
        bus.d_we = 1'b1; bus.d_dataout = 16'hDEAD;
        step();
        bus.d_we = 1'b0;
        #1;
        check("dmem_idle_write", 32'(bus.d_datain), 32'hBEEF);

        // ld_last on a high byte
        send(8'hAB, 1'b1);
        step(); step();
        check("odd_count", 32'(bus.ld_count), 32'd1);
        check("odd_err",   32'(bus.err),      32'd1);
        peek_imem("odd_imem0", 8'h00, 16'hAB00);
        stop_run();
        check("stop_err_clear", 32'(bus.err), 32'd0);

        // Stall mid-word, reloading from address 0
        p0 = pulses;
        send(8'h12, 1'b0);
        step(); step(); step();
        send(8'h34, 1'b1);
        step(); step(); step();
        check("stall_pulses", 32'(pulses), 32'(p0 + 1));
        check("stall_count",  32'(bus.ld_count), 32'd1);
        peek_imem("stall_imem0", 8'h00, 16'h1234);

        // Bytes offered in RUN are not accepted
        bus.ld_valid = 1'b1; bus.ld_data = 8'h77;
        step(); step();
        bus.ld_valid = 1'b0;
        check("run_ignore_count", 32'(bus.ld_count), 32'd1);
        stop_run();

        // Reset mid-word discards the pending high byte
        send(8'h55, 1'b0);
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        bus.ld_valid = 1'b1; bus.ld_data = 8'h66;
        step();
        reset = 1'b0;
        bus.ld_valid = 1'b0;
        check("mid_rst_count", 32'(bus.ld_count), 32'd0);
        check("mid_rst_busy",  32'(bus.busy),     32'd0);
        peek_imem("mid_rst_imem0", 8'h00, 16'h1234);
        send(8'h77, 1'b1);
        step();
        peek_imem("after_rst_imem0", 8'h00, 16'h7700);
        check("after_rst_count", 32'(bus.ld_count), 32'd1);
        step();
        stop_run();

        // Full 256-word load without ld_last
        for (int w = 0; w < 256; w++) begin
            send(8'(w), 1'b0);
            send(~8'(w), 1'b0);
        end
        check("full_start", 32'(bus.cpu_start), 32'd1);
        step(); step();
        check("full_count",  32'(bus.ld_count),   32'd256);
        check("full_err",    32'(bus.err),        32'd1);
        check("full_enable", 32'(bus.cpu_enable), 32'd1);
        peek_imem("full_imem255", 8'hFF, 16'hFF00);
        peek_imem("full_imem0",   8'h00, 16'h00FF);
        peek_imem("full_imem128", 8'h80, 16'h807F);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pmem_loader.md
PMEM_LOADER -- requirements
Module: pmem_loader

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 SHALL have the following ports (clock and reset first):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- i_addr  in  8  CPU instruction word address
- i_datain  out  16  instruction word returned to the CPU
- d_addr  in  8  CPU data word address
- d_dataout  in  16  CPU store data
- d_we  in  1  CPU store strobe
- d_datain  out  16  load data returned to the CPU
- ld_valid  in  1  loader byte valid
- ld_data  in  8  loader byte
- ld_last  in  1  marks the final loader byte
- ld_ready  out  1  loader byte accept
- run_stop  in  1  host request to stop the CPU
- cpu_enable  out  1  drives CPU enable
- cpu_start  out  1  drives CPU start; one-cycle pulse
- busy  out  1  high in LOAD and START
- ld_count  out  9  count of words written to imem
- err  out  1  sticky load-format error

Function
REQ-003 SHALL contain imem and dmem, each 256 x 16.
REQ-004 SHALL drive i_datain = imem[i_addr] and d_datain = dmem[d_addr] combinationally, with zero-cycle read latency.
- A read that coincides with a write in the same cycle returns the old content; the new content is visible after the clock edge.
REQ-005 SHALL implement FSM states IDLE, LOAD, START, RUN.
REQ-006 SHALL drive ld_ready = 1 in IDLE and LOAD, and 0 in START and RUN.
- A byte is accepted only on a cycle where ld_valid and ld_ready are both 1.
REQ-007 SHALL assemble each imem word big-endian: the first accepted byte is [15:8], the second is [7:0].
- The word is written to imem[ld_count[7:0]] at the edge that accepts its low byte.
- ld_count increments at that same edge.
REQ-008 SHALL transition IDLE -> LOAD on the first accepted byte.
- Bytes with ld_valid = 0 cause no state or phase change; a stall mid-word is allowed.
REQ-009 SHALL handle ld_last on a low byte as follows: write the word, then go LOAD -> START.
REQ-010 SHALL handle ld_last on a high byte as follows:
- write {byte, 8'h00} to the current address;
- increment ld_count;
- set err;
- go to START.
REQ-011 SHALL, when the 256th word is written without ld_last:
- go to START;
- set err;
- never wrap the imem address during a load.
REQ-012 SHALL in START drive cpu_start = 1 and cpu_enable = 1 for exactly one cycle, then go to RUN.
REQ-013 SHALL in RUN hold cpu_enable = 1 and cpu_start = 0.
REQ-014 SHALL write dmem[d_addr] <= d_dataout at the edge where d_we = 1, only in RUN.
- d_we is ignored in all other states.
REQ-015 SHALL, on run_stop = 1 in RUN, do all of the following at the next edge:
- go to IDLE;
- drop cpu_enable;
- clear ld_count;
- clear err.
- A d_we in that same cycle is still honoured.
- run_stop is ignored outside RUN.
REQ-016 SHALL leave cpu_enable = 0 in IDLE and LOAD.
- busy = 1 exactly in LOAD and START.

Reset
REQ-017 SHALL, on reset = 1 at a rising edge, set:
- state = IDLE;
- ld_count = 0;
- err = 0;
- byte phase = high;
- cpu_enable = 0;
- cpu_start = 0;
- busy = 0;
- ld_ready = 1 (from the next cycle).
REQ-018 SHALL give reset priority over every other input, including mid-LOAD and in RUN.
- Any partial word is discarded.
REQ-019 SHALL NOT let reset clear imem or dmem contents.

Verification
REQ-020 SHALL cover these directed scenarios:
- Reset held 2 cycles -> ld_ready = 1, cpu_enable = 0, cpu_start = 0, busy = 0, ld_count = 0, err = 0.
- Bytes 0x12, 0x34, 0x56, 0x78 (last) -> imem[0] = 0x1234, imem[1] = 0x5678, ld_count = 2, err = 0; cpu_start high exactly 1 cycle; cpu_enable then stays 1; i_addr = 1 gives i_datain = 0x5678.
- Byte 0x12, then ld_valid low 3 cycles, then 0x34 (last) -> imem[0] = 0x1234, single START pulse.
- Byte 0xAB with ld_last -> imem[0] = 0xAB00, ld_count = 1, err = 1.
- In RUN, d_we = 1, d_addr = 0x10, d_dataout = 0xBEEF -> same-cycle d_datain is the old value; next cycle d_datain = 0xBEEF. The same write issued in IDLE leaves dmem[0x10] unchanged.
- run_stop in RUN -> next cycle IDLE, cpu_enable = 0, ld_count = 0; a new load writes from address 0.
- Reset asserted mid-word during LOAD -> IDLE, ld_count = 0, and no imem write occurs.
